sensor_sample_sequencer: RTL and testbench
==========================================

// Module: sensor_sample_sequencer
// PURPOSE
//   Producer side of the sensor interface that the irrigation FSM consumes.
//   On each sample_tick it steps the ADC through four channels and captures one 8-bit result per channel.
//   Channels: 0 moisture, 1 light, 2 moisture-threshold pot, 3 light-threshold pot.
//   It then publishes m_sense, l_sense, m_thresh_1 and l_thresh together as one coherent frame.
// PARAMETERS
//   SETTLE_CYCLES   4    cycles adc_mux is held stable before adc_start (>=1)
//   TIMEOUT_CYCLES  255  max cycles to wait for adc_done after adc_start (>=2)
// PORTS
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   sample_tick  in   1  one-cycle pulse requesting a new frame
//   adc_data     in   8  ADC conversion result, valid while adc_done=1
//   adc_done     in   1  ADC conversion complete
//   err_clr      in   1  clears adc_err and overrun
//   adc_mux      out  2  ADC channel select
//   adc_start    out  1  one-cycle conversion start pulse
//   m_sense      out  8  published moisture reading
//   l_sense      out  8  published light reading
//   m_thresh_1   out  8  published moisture threshold
//   l_thresh     out  2  published light threshold = adc_data[7:6] of channel 3
//   frame_valid  out  1  one-cycle pulse when a new frame is published
//   busy         out  1  high whenever state != IDLE
//   adc_err      out  4  sticky per-channel timeout flags
//   overrun      out  1  sticky; set by sample_tick while busy
// BEHAVIOUR
//   Reset values:
//     m_sense = 8'hFF (reads as wet, so no watering at power-up); all other outputs 0.
//     State = IDLE; counters and shadow registers cleared.
//   FSM: IDLE -> SETTLE -> START -> WAIT -> (next channel SETTLE | PUBLISH) -> IDLE.
//   IDLE: sample_tick=1 at edge T -> adc_mux=0 and SETTLE from cycle T+1.
//   SETTLE: SETTLE_CYCLES cycles, adc_mux stable.
//   START: exactly 1 cycle with adc_start=1.
//   WAIT:
//     - adc_done is honoured only in WAIT; adc_done during SETTLE/START is ignored.
//     - Capture adc_data into the channel shadow on the cycle adc_done=1.
//     - Then adc_mux increments, or go to PUBLISH after channel 3.
//   Timeout:
//     - If adc_done is not seen within TIMEOUT_CYCLES WAIT cycles: set adc_err[ch] and keep the old shadow value.
//     - Then advance exactly as on done.
//     - adc_done on the final timeout cycle counts as done; no error.
//   Channel duration = SETTLE_CYCLES + 1 + k cycles, where k = WAIT cycles until done.
//   PUBLISH (1 cycle):
//     - Copy all shadows to the outputs on one edge.
//     - frame_valid=1 in the following cycle with the new values.
//     - Outputs never change mid-frame.
//   sample_tick while busy (including PUBLISH): ignored, overrun<=1. No queuing.
//   err_clr clears adc_err/overrun. err_clr and a new error on the same edge: the set wins.
//   Reset mid-frame: adc_start=0 and all outputs at reset values from the next cycle; the partial frame is discarded.
// CONFIGURATION
//   SENSOR_AVG_EN defined:
//     - Moisture uses a 4-deep history; m_sense = (h0+h1+h2+h3) >> 2.
//     - 10-bit sum, truncating.
//     - The first successful moisture capture after reset fills all 4 entries.
//     - A timed-out moisture sample does not enter the history.
//   SENSOR_AVG_EN undefined: m_sense = raw channel-0 capture. No history logic.
// TESTING
//   1. ADC model done k=3 cycles after start; tick at T:
//      - adc_start pulses at T+5, T+13, T+21, T+29; frame_valid at T+33.
//      - Outputs equal channel data 0x80/0x40/0xA0/0xC0 -> l_thresh=2'b11.
//   2. Channel 1 ADC never responds:
//      - adc_err=4'b0010; l_sense keeps its prior value; frame completes.
//      - err_clr -> adc_err=0.
//   3. Second sample_tick 5 cycles after the first:
//      - overrun=1; exactly one frame_valid.
//   4. reset asserted during channel 2 WAIT:
//      - Next cycle adc_start=0, m_sense=8'hFF, other outputs 0, busy=0.
//   5. SENSOR_AVG_EN, moisture samples 100, 200, 200, 200:
//      - m_sense = 100, 125, 150, 175. Undefined: 100, 200, 200, 200.
//   6. adc_done held high during SETTLE/START:
//      - Not captured early; capture occurs only in WAIT.

Source files
------------

// File: rtl/sensor_sample_sequencer.sv
// sensor_sample_sequencer: steps the ADC through 4 channels per sample_tick and publishes one coherent frame
// SENSOR_AVG_EN: when defined, m_sense is the truncated mean of a 4-deep moisture history
module sensor_sample_sequencer #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic [7:0] adc_data,
  input  logic       adc_done,
  input  logic       err_clr,
  output logic [1:0] adc_mux,
  output logic       adc_start,
  output logic [7:0] m_sense,
  output logic [7:0] l_sense,
  output logic [7:0] m_thresh_1,
  output logic [1:0] l_thresh,
  output logic       frame_valid,
  output logic       busy,
  output logic [3:0] adc_err,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, PUBLISH} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0][7:0] sh;
  logic done_ok, tout, adv;
  logic [7:0] cap;
`ifdef SENSOR_AVG_EN
  logic [3:0][7:0] hist;
  logic filled;
  logic [9:0] sum;
  assign sum = 10'(hist[0]) + 10'(hist[1]) + 10'(hist[2]) + 10'(hist[3]);
`endif
  always_comb begin
    done_ok = state == WAIT && adc_done;
    tout = state == WAIT && !adc_done && cnt == CW'(TIMEOUT_CYCLES - 1);
    adv = done_ok || tout;
    cap = done_ok ? adc_data : sh[adc_mux];
    adc_start = state == START;
    busy = state != IDLE;
    frame_valid = state == PUBLISH;
    state_n = state;
    unique case (state)
      IDLE:    state_n = sample_tick ? SETTLE : IDLE;
      SETTLE:  state_n = cnt == CW'(SETTLE_CYCLES - 1) ? START : SETTLE;
      START:   state_n = WAIT;
      WAIT:    state_n = !adv ? WAIT : adc_mux == 2'd3 ? PUBLISH : SETTLE;
      PUBLISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      adc_mux <= '0;
      sh <= '0;
      m_sense <= 8'hFF;
      l_sense <= '0;
      m_thresh_1 <= '0;
      l_thresh <= '0;
      adc_err <= '0;
      overrun <= 1'b0;
`ifdef SENSOR_AVG_EN
      hist <= '0;
      filled <= 1'b0;
`endif
    end else begin
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      adc_err <= (err_clr ? 4'b0 : adc_err) | (tout ? 4'b1 << adc_mux : 4'b0);
      overrun <= (overrun & ~err_clr) | (sample_tick & busy);
      if (adv) begin
        sh[adc_mux] <= cap;
        adc_mux <= adc_mux + 1'b1;
      end
      // Channel 3 finishes on the publish edge, so its value bypasses the shadow
      if (adv && adc_mux == 2'd3) begin
`ifdef SENSOR_AVG_EN
        m_sense <= sum[9:2];
`else
        m_sense <= sh[0];
`endif
        l_sense <= sh[1];
        m_thresh_1 <= sh[2];
        l_thresh <= cap[7:6];
      end
`ifdef SENSOR_AVG_EN
      if (done_ok && adc_mux == 2'd0) begin
        hist <= filled ? {hist[2:0], adc_data} : {4{adc_data}};
        filled <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_sensor_sample_sequencer.sv
// tb_sensor_sample_sequencer: directed bench with ADC model and frame scoreboard
module tb_sensor_sample_sequencer;
  logic clk = 0, reset = 1, sample_tick = 0, err_clr = 0;
  logic adc_done;
  logic [7:0] adc_data;
  logic [1:0] adc_mux, l_thresh;
  logic adc_start, frame_valid, busy, overrun;
  logic [7:0] m_sense, l_sense, m_thresh_1;
  logic [3:0] adc_err;
  sensor_sample_sequencer dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .adc_data(adc_data),
    .adc_done(adc_done), .err_clr(err_clr), .adc_mux(adc_mux), .adc_start(adc_start),
    .m_sense(m_sense), .l_sense(l_sense), .m_thresh_1(m_thresh_1), .l_thresh(l_thresh),
    .frame_valid(frame_valid), .busy(busy), .adc_err(adc_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, fv_count = 0, fv_cyc = 0, dcnt = 0;
  typedef struct packed {logic [7:0] m, l, mt; logic [1:0] lt;} frame_t;
  frame_t sb[$];
  logic [7:0] chd [4];
  logic [3:0] mute = 0;
  logic hold_done = 0, garble = 0, seen = 0, pulse = 0;
  logic [1:0] last_mux = 0;
  logic [7:0] ex_m = 8'hFF, ex_l = 0, ex_mt = 0, ex_lt = 0;
`ifdef SENSOR_AVG_EN
  logic [7:0] hist [4];
  logic filled = 0;
`endif
  assign adc_done = pulse | hold_done;
  assign adc_data = (garble && !seen) ? 8'hEE : chd[adc_mux];
  always @(posedge clk) cyc++;
  // ADC model: done pulses 3 cycles after start unless the channel is muted
  always @(negedge clk) begin
    if (adc_start) begin
      seen = 1;
      if (!mute[adc_mux]) dcnt = 3;
      pulse = 0;
    end else if (dcnt > 0) begin
      dcnt--;
      pulse = dcnt == 0;
    end else pulse = 0;
    if (adc_mux != last_mux) seen = 0;
    last_mux = adc_mux;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      frame_t f;
      fv_count++;
      fv_cyc = cyc;
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        f = sb.pop_front();
        chk("m_sense", m_sense, f.m);
        chk("l_sense", l_sense, f.l);
        chk("m_thresh_1", m_thresh_1, f.mt);
        chk("l_thresh", l_thresh, f.lt);
      end
    end
  end
  function automatic logic [7:0] model_m(input logic [7:0] d);
`ifdef SENSOR_AVG_EN
    logic [9:0] s;
    if (!filled) hist = '{d, d, d, d};
    else hist = '{hist[1], hist[2], hist[3], d};
    filled = 1;
    s = 10'(hist[0]) + 10'(hist[1]) + 10'(hist[2]) + 10'(hist[3]);
    return s[9:2];
`else
    return d;
`endif
  endfunction
  task automatic push_frame();
    if (!mute[0]) ex_m = model_m(chd[0]);
    if (!mute[1]) ex_l = chd[1];
    if (!mute[2]) ex_mt = chd[2];
    if (!mute[3]) ex_lt = chd[3];
    sb.push_back('{ex_m, ex_l, ex_mt, ex_lt[7:6]});
  endtask
  task automatic tick();
    sample_tick = 1;
    @(negedge clk);
    sample_tick = 0;
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m"}, m_sense, 8'hFF);
    chk({tag, "_l"}, l_sense, 0);
    chk({tag, "_mt"}, m_thresh_1, 0);
    chk({tag, "_lt"}, l_thresh, 0);
    chk({tag, "_err"}, adc_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_fv"}, frame_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, adc_start, 0);
    chk({tag, "_mux"}, adc_mux, 0);
  endtask
  initial begin
    int base, fvc, n;
    int starts[$];
    logic [7:0] mv [4];
    chd = '{8'h80, 8'h40, 8'hA0, 8'hC0};
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 0;
    repeat (2) @(negedge clk);
    // nominal frame and its cycle timing
    push_frame();
    base = cyc;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (adc_start) starts.push_back(cyc - base);
      @(negedge clk);
    end
    chk("n_starts", starts.size(), 4);
    for (int i = 0; i < 4 && i < starts.size(); i++) chk("start_cyc", starts[i], 5 + 8 * i);
    chk("fv_cyc", fv_cyc - base, 33);
    chk("lt_11", l_thresh, 2'b11);
    chk("err_none", adc_err, 0);
    // channel 1 silent: timeout flag, l_sense held
    chd = '{8'h11, 8'h22, 8'h33, 8'h44};
    mute = 4'b0010;
    push_frame();
    tick();
    wait_idle(600);
    chk("err_ch1", adc_err, 4'b0010);
    mute = 0;
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("err_clr", adc_err, 0);
    // overrun on a second tick while busy
    chd = '{8'h55, 8'h66, 8'h77, 8'h88};
    fvc = fv_count;
    push_frame();
    tick();
    repeat (4) @(negedge clk);
    tick();
    wait_idle(100);
    repeat (10) @(negedge clk);
    chk("overrun", overrun, 1);
    chk("one_frame", fv_count - fvc, 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("ovr_clr", overrun, 0);
    // reset during channel 2 WAIT
    n = 0;
    tick();
    fvc = 0;
    while (fvc < 3 && n < 100) begin
      if (adc_start) fvc++;
      @(negedge clk);
      n++;
    end
    chk("ch2_reached", fvc, 3);
    reset = 1;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 0;
    ex_m = 8'hFF; ex_l = 0; ex_mt = 0; ex_lt = 0;
`ifdef SENSOR_AVG_EN
    filled = 0;
`endif
    repeat (5) @(negedge clk);
    // moisture sequence, checked through the scoreboard
    mv = '{8'd100, 8'd200, 8'd200, 8'd200};
    for (int i = 0; i < 4; i++) begin
      chd[0] = mv[i];
      push_frame();
      tick();
      wait_idle(100);
    end
    chk("m_last", m_sense,
`ifdef SENSOR_AVG_EN
      8'd175
`else
      8'd200
`endif
    );
    // adc_done held high: capture only once the conversion has started
    chd = '{8'h12, 8'h34, 8'h56, 8'h9A};
    garble = 1;
    hold_done = 1;
    push_frame();
    tick();
    wait_idle(100);
    hold_done = 0;
    garble = 0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("err_final", adc_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
